// File: rtl/sseg_pkg.sv
// rtl/sseg_pkg.sv - shared constants and helpers for the seven-segment scan driver
package sseg_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] AN_OFF  = 4'hF;

    typedef enum logic [1:0] {
        DUTY_FULL    = 2'd0,
        DUTY_HALF    = 2'd1,
        DUTY_QUARTER = 2'd2,
        DUTY_EIGHTH  = 2'd3
    } duty_e;

    function automatic logic [3:0] an_select(input logic [1:0] dig);
        return ~(4'b0001 << dig);
    endfunction

endpackage

// File: rtl/scan_counter.sv
// rtl/scan_counter.sv - free-running N-bit refresh counter with wrap flag
module scan_counter #(
    parameter int N = 18
) (
    input  logic         clk,
    input  logic         rst,
    output logic [N-1:0] q,
    output logic         wrap
);

    logic [N-1:0] q_q;
    logic [N-1:0] q_d;

    always_comb begin
        q_d = q_q + N'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q    = q_q;
    assign wrap = &q_q;

endmodule

// File: rtl/sseg_scan_driver.sv
// rtl/sseg_scan_driver.sv - 4-digit multiplexed display driver with frame-synchronous updates
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int N     = 18,
    parameter int GUARD = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in3,
    input  logic [7:0] in2,
    input  logic [7:0] in1,
    input  logic [7:0] in0,
    input  logic       load,
    input  logic [3:0] blank,
    input  logic [1:0] duty,
    output logic [3:0] an,
    output logic [7:0] sseg,
    output logic       busy,
    output logic       frame_tick
);

    localparam logic [N-2:0] SLOT = (N-1)'(1) << (N-2);

    logic [N-1:0] q;
    logic         wrap;

    logic [31:0]  stg_pat_q, stg_pat_d;
    logic [31:0]  act_pat_q, act_pat_d;
    duty_e        stg_duty_q, stg_duty_d;
    duty_e        act_duty_q, act_duty_d;
    logic         busy_q, busy_d;
    logic [3:0]   an_q, an_d;
    logic [7:0]   sseg_q, sseg_d;
    logic         tick_q, tick_d;

    logic [1:0]   dig;
    logic [N-3:0] pos;
    logic [N-2:0] limit;
    logic         lit;

    scan_counter #(.N(N)) u_scan_counter (
        .clk  (clk),
        .rst  (reset),
        .q    (q),
        .wrap (wrap)
    );

    always_comb begin
        stg_pat_d  = stg_pat_q;
        stg_duty_d = stg_duty_q;
        act_pat_d  = act_pat_q;
        act_duty_d = act_duty_q;
        busy_d     = busy_q;

        // Promotion reads the old staging, so a load on the wrap cycle waits a frame.
        if (wrap && busy_q) begin
            act_pat_d  = stg_pat_q;
            act_duty_d = stg_duty_q;
            busy_d     = 1'b0;
        end
        if (load) begin
            stg_pat_d  = {in3, in2, in1, in0};
            stg_duty_d = duty_e'(duty);
            busy_d     = 1'b1;
        end

        dig   = q[N-1:N-2];
        pos   = q[N-3:0];
        limit = SLOT >> act_duty_q;
        lit   = ({1'b0, pos} >= (N-1)'(GUARD)) && ({1'b0, pos} < limit) && !blank[dig];

        an_d   = lit ? an_select(dig) : AN_OFF;
        sseg_d = lit ? act_pat_q[{dig, 3'b000} +: 8] : SEG_OFF;
        tick_d = wrap;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stg_pat_q  <= {4{SEG_OFF}};
            act_pat_q  <= {4{SEG_OFF}};
            stg_duty_q <= DUTY_FULL;
            act_duty_q <= DUTY_FULL;
            busy_q     <= 1'b0;
            an_q       <= AN_OFF;
            sseg_q     <= SEG_OFF;
            tick_q     <= 1'b0;
        end else begin
            stg_pat_q  <= stg_pat_d;
            act_pat_q  <= act_pat_d;
            stg_duty_q <= stg_duty_d;
            act_duty_q <= act_duty_d;
            busy_q     <= busy_d;
            an_q       <= an_d;
            sseg_q     <= sseg_d;
            tick_q     <= tick_d;
        end
    end

    assign an         = an_q;
    assign sseg       = sseg_q;
    assign busy       = busy_q;
    assign frame_tick = tick_q;

endmodule
